// File: rtl/edge_meter_pkg.sv
// Shared constants, FSM encoding and helpers for the edge period meter.
package edge_meter_pkg;

    localparam int unsigned WIDTH_DEFAULT       = 8;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_e;

    // Largest value a w-bit counter can hold (w <= 31).
    function automatic int unsigned sat_value(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-flop synchronizer for an asynchronous input plus a rising-edge strobe.
module sync_rise_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Shift the raw input through the synchronizer chain and remember the last synchronized level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_sync = sync_q[SYNC_STAGES-1];
    assign rise   = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/edge_period_meter.sv
// Measures clk cycles between rising edges of an asynchronous input and presents
// each measurement through a valid/ready handshake with a sticky overrun flag.
module edge_period_meter
    import edge_meter_pkg::*;
#(
    parameter int unsigned WIDTH       = WIDTH_DEFAULT,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic             overflow,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             overrun
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(sat_value(WIDTH));

    meter_state_e     state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_d;
    logic             overflow_d;
    logic             valid_d;
    logic             overrun_d;
    logic             sig_sync;
    logic             rise;
    logic             edge_c;

    sync_rise_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (sig_in),
        .q_sync (sig_sync),
        .rise   (rise)
    );

    // A rise strobe always coincides with a high synchronized level.
    assign edge_c = rise & sig_sync;

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            period       <= '0;
            overflow     <= 1'b0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period       <= period_d;
            overflow     <= overflow_d;
            period_valid <= valid_d;
            overrun      <= overrun_d;
        end
    end

    // Next-state: arm on first edge, count between edges, capture and hand off on later edges.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period;
        overflow_d = overflow;
        valid_d    = period_valid;
        overrun_d  = overrun;

        if (period_valid && period_ready) begin
            valid_d = 1'b0;
        end

        if (clear) begin
            state_d    = IDLE;
            cnt_d      = '0;
            period_d   = '0;
            overflow_d = 1'b0;
            valid_d    = 1'b0;
            overrun_d  = 1'b0;
        end else if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (edge_c) begin
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (edge_c) begin
                        period_d   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + WIDTH'(1);
                        overflow_d = (cnt_q == CNT_MAX);
                        cnt_d      = '0;
                        valid_d    = 1'b1;
                        if (period_valid && !period_ready) begin
                            overrun_d = 1'b1;
                        end
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_period_meter.sv
// Scoreboard bench for edge_period_meter: the stimulus predicts each capture from
// the edge timeline, and a monitor tracks the handshake outputs cycle by cycle.
module tb_edge_period_meter;

    localparam int unsigned W    = 8;
    localparam int          SATV = 255;

    typedef struct {
        int cap;
        int per;
        int ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable;
    logic         clear;
    logic         sig_in;
    logic [W-1:0] period;
    logic         overflow;
    logic         period_valid;
    logic         period_ready;
    logic         overrun;

    exp_t q[$];
    int   pe = 0;
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;
    bit   done = 1'b0;
    bit   fin = 1'b0;

    // stimulus-side model of arming
    bit   armed = 1'b0;
    int   last_edge = 0;

    // monitor-side model of the output registers
    int   m_valid = 0;
    int   m_per = 0;
    int   m_ovf = 0;
    int   m_ovr = 0;
    int   prev_ready = 0;
    int   prev_clear = 0;

    edge_period_meter #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .clear        (clear),
        .sig_in       (sig_in),
        .period       (period),
        .overflow     (overflow),
        .period_valid (period_valid),
        .period_ready (period_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pe++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, pe);
        end
    endtask

    task automatic compare_all();
        check("period_valid", int'(period_valid), m_valid);
        check("period", int'(period), m_per);
        check("overflow", int'(overflow), m_ovf);
        check("overrun", int'(overrun), m_ovr);
    endtask

    // Monitor: step the handshake model for the edge just taken and compare.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            m_valid = 0; m_per = 0; m_ovf = 0; m_ovr = 0;
            compare_all();
            prev_ready = int'(period_ready);
            prev_clear = int'(clear);
        end else begin
            int old_valid;
            old_valid = m_valid;
            if (prev_clear != 0) begin
                m_valid = 0; m_per = 0; m_ovf = 0; m_ovr = 0;
            end else begin
                if (old_valid != 0 && prev_ready != 0) m_valid = 0;
                if (q.size() > 0 && q[0].cap == pe) begin
                    exp_t e;
                    e = q.pop_front();
                    if (old_valid != 0 && prev_ready == 0) m_ovr = 1;
                    m_valid = 1;
                    m_per   = e.per;
                    m_ovf   = e.ovf;
                end
            end
            compare_all();
            prev_ready = int'(period_ready);
            prev_clear = int'(clear);
            if (done && !fin) begin
                check("queue_empty", q.size(), 0);
                fin = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) period_ready = 1'($urandom_range(0, 1));
    endtask

    // Raise sig_in now and predict the capture it produces.
    task automatic rise_sig();
        sig_in = 1'b1;
        if (enable) begin
            if (armed) begin
                exp_t e;
                int   d;
                d     = pe - last_edge;
                e.cap = pe + 3;
                e.per = (d > SATV) ? SATV : d;
                e.ovf = (d > SATV) ? 1 : 0;
                q.push_back(e);
            end
            armed = 1'b1;
        end
        last_edge = pe;
    endtask

    // Next rising edge n cycles after the previous one; high for about half the gap.
    task automatic edge_after(input int n);
        int half;
        int target;
        half   = last_edge + n / 2;
        target = last_edge + n;
        while (pe < half) tick();
        sig_in = 1'b0;
        while (pe < target) tick();
        rise_sig();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        armed = 1'b0;
    endtask

    initial begin
        enable       = 1'b1;
        clear        = 1'b0;
        sig_in       = 1'b0;
        period_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        last_edge = pe;

        // basic period: arm plus four captures of 10
        rise_sig();
        repeat (4) edge_after(10);

        // saturation boundary
        edge_after(255);
        edge_after(256);
        edge_after(300);
        repeat (5) tick();

        // backpressure with overrun, then a single-cycle accept
        do_clear();
        period_ready = 1'b0;
        edge_after(10);
        edge_after(20);
        edge_after(30);
        repeat (5) tick();
        period_ready = 1'b1;
        tick();
        period_ready = 1'b0;
        repeat (4) tick();
        do_clear();

        // accept and capture on the same edge
        edge_after(15);
        edge_after(15);
        edge_after(15);
        tick();
        tick();
        period_ready = 1'b1;
        tick();
        period_ready = 1'b0;
        repeat (3) tick();
        period_ready = 1'b1;

        // clear five cycles after an edge, then re-arm
        edge_after(10);
        repeat (5) tick();
        do_clear();
        edge_after(10);
        edge_after(12);

        // drop enable mid-measurement, edge while disabled, then re-arm
        repeat (5) tick();
        enable = 1'b0;
        armed  = 1'b0;
        edge_after(10);
        repeat (5) tick();
        enable = 1'b1;
        edge_after(9);
        edge_after(12);

        // asynchronous reset with a pending capture
        period_ready = 1'b0;
        edge_after(8);
        repeat (5) tick();
        sig_in = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        armed = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        period_ready = 1'b1;
        repeat (2) tick();
        edge_after(7);
        edge_after(7);
        repeat (5) tick();

        // randomized gaps and randomized ready
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) edge_after(int'($urandom_range(250, 270)));
            else        edge_after(int'($urandom_range(2, 40)));
        end
        repeat (5) tick();
        rand_ready   = 1'b0;
        period_ready = 1'b1;
        repeat (5) tick();

        done = 1'b1;
        for (int i = 0; i < 10 && !fin; i++) tick();
        if (!fin) begin
            errors++;
            $display("FAIL monitor_finish: got 0 expected 1");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/edge_period_meter.md
Name: edge_period_meter

Overview:
- Measures the period, in clk cycles, between consecutive rising edges of an asynchronous input.
- It is the receive end of the team's loadable 8-bit counter outputs: a counter bit or external waveform is fed back in through a dedicated input pin, and the measured period is read out.
- Contents: 2-flop synchronizer, rising-edge detector, saturating interval counter, capture register, and a valid/ready output handshake with overrun flag.

Parameters:
- WIDTH, 8, width of the interval counter and of `period`; the saturation value is 2^WIDTH-1.
- SYNC_STAGES, 2, number of synchronizer flops on `sig_in`; must be 2 or more.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  1 = measuring. 0 = the FSM is held in IDLE and the counter is cleared. The synchronizer keeps running.
- clear  in  1  synchronous one-cycle clear: FSM goes to IDLE, counter to 0, `period_valid`/`overflow`/`overrun` to 0.
- sig_in  in  1  asynchronous waveform to measure.
- period  out  WIDTH  last captured period in cycles, saturating.
- overflow  out  1  qualifies `period`: 1 = the true period exceeded 2^WIDTH-1.
- period_valid  out  1  capture pending.
- period_ready  in  1  consumer accepts; a transfer occurs when valid & ready at a clk edge.
- overrun  out  1  sticky: a capture overwrote an unaccepted one.

Behaviour:
- Reset (rst_n=0, asynchronous): synchronizer flops and the edge-history flop = 0, FSM = IDLE, counter = 0. Outputs: `period`=0, `overflow`=0, `period_valid`=0, `overrun`=0.
- Edge detect: `rise` = last sync stage & ~history flop.
  - `sig_in` first sampled high at edge k → `rise` is true between edges k+SYNC_STAGES-1 and k+SYNC_STAGES.
  - The capture registers at edge k+SYNC_STAGES.
  - Pulses shorter than one clk period may be missed; this is not an error.
- FSM, two states:
  - IDLE: counter held at 0. On `rise` & `enable` → MEASURE, counter := 0, no capture. The first edge only arms the meter.
  - MEASURE:
    - Each cycle without `rise`: counter := counter+1, saturating at 2^WIDTH-1. The counter never wraps.
    - On `rise`: `period` := min(counter+1, 2^WIDTH-1); `overflow` := (counter == 2^WIDTH-1); counter := 0; remain in MEASURE.
  - Edges spaced N cycles apart give `period`=N for N ≤ 2^WIDTH-1. N = 2^WIDTH-1 gives `overflow`=0; N ≥ 2^WIDTH gives `period`=max and `overflow`=1.
  - `enable`=0 or `clear`=1 in any state → IDLE, counter := 0. `clear` takes priority over `rise` in the same cycle.
- Handshake:
  - A capture sets `period_valid`=1.
  - `period_valid` falls on the edge where valid & ready, unless a capture occurs on the same edge; then it stays 1 with the new data and no overrun.
  - `period` and `overflow` are stable while `period_valid`=1 and no new capture occurs.
  - Capture while valid & !ready: data overwritten, `period_valid` stays 1, `overrun` := 1.
  - `overrun` is cleared only by `clear` or reset.
- `enable`=0 does not drop a pending `period_valid`; the consumer can still drain it.
- Reset asserted mid-measurement discards all state. After release, the first edge only re-arms.
- `ready` with `period_valid`=0 has no effect.

Decomposition:
- Package `edge_meter_pkg`: WIDTH default constant; FSM state enum {IDLE, MEASURE}; localparam function for the saturation value.
- Sub-module `sync_rise_detect` (parameter SYNC_STAGES; ports clk, rst_n, d, q_sync, rise). It is reusable for the team's other `ui_in`-sampled inputs.
- The top level holds the FSM, counter, capture and handshake logic.

Test Plan:
- Basic period: WIDTH=8, ready=1, `sig_in` square wave with rising edges every 10 cycles, 5 edges → 4 captures, each `period`=10, `overflow`=0. The first edge produces no `period_valid`.
- Saturation boundary: rising-edge spacings of 255, then 256, then 300 → `period` 255/`overflow` 0, then 255/1, then 255/1. The counter does not wrap.
- Backpressure: ready=0, spacing 20 then 30 → after the 2nd capture `period`=30, `period_valid`=1, `overrun`=1. Then ready=1 for 1 cycle → `period_valid`=0; `overrun` stays 1 until `clear`.
- Same-edge accept+capture: hold valid, raise ready on exactly the capture edge → `period_valid` stays 1 with the new value, `overrun`=0.
- Clear/enable: pulse `clear` 5 cycles after an edge → all outputs 0, FSM IDLE. The next edge only arms; the following edge 12 cycles later gives `period`=12. Drop `enable` mid-measurement → same re-arm behaviour.
- Async reset: assert rst_n=0 between clk edges mid-MEASURE with `period_valid`=1 → all outputs 0 immediately. After release, edge spacing 7 gives its first capture only on the second edge, `period`=7.
